// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a 4-digit seven-segment display. A prescaler
//   sets how long each digit stays lit, and a 2-bit index walks the digits.
//   New contents are double-buffered. They only reach the display at a frame
//   boundary, which is the tick that ends digit 3. This keeps a frame from
//   ever showing a mix of old and new digits.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   load         one-cycle request to capture digits_in / blank_in
//   digits_in    four hex nibbles, [3:0] = digit 0 (rightmost)
//   blank_in     per-digit blank request, bit n blanks digit n
//   anode        active-low digit enable, at most one bit low
//   digit_out    nibble of the scanned digit, for the segment decoder
//   update_ack   one-cycle pulse when captured contents become displayed
//   frame_start  one-cycle pulse when the scan wraps from digit 3 to digit 0
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  anode,
    output logic [3:0]  digit_out,
    output logic        update_ack,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   act_dig_q, act_dig_d;
    logic [3:0]    act_blk_q, act_blk_d;
    logic [15:0]   pend_dig_q, pend_dig_d;
    logic [3:0]    pend_blk_q, pend_blk_d;
    logic          pend_vld_q, pend_vld_d;
    logic          ack_q, ack_d;
    logic          fs_q, fs_d;

    logic tick;
    logic boundary;

    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        boundary = tick && (idx_q == 2'd3);

        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
        act_dig_d  = act_dig_q;
        act_blk_d  = act_blk_q;
        pend_dig_d = pend_dig_q;
        pend_blk_d = pend_blk_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        fs_d       = boundary;

        if (boundary) begin
            // A load that lands on the boundary cycle bypasses the pending
            // buffer. It also takes priority over an older pending value.
            if (load) begin
                act_dig_d  = digits_in;
                act_blk_d  = blank_in;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end else if (pend_vld_q) begin
                act_dig_d  = pend_dig_q;
                act_blk_d  = pend_blk_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (load) begin
            // If several loads arrive in one frame, the last one wins.
            pend_dig_d = digits_in;
            pend_blk_d = blank_in;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_dig_q  <= '0;
            act_blk_q  <= '0;
            pend_dig_q <= '0;
            pend_blk_q <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_dig_q  <= act_dig_d;
            act_blk_q  <= act_blk_d;
            pend_dig_q <= pend_dig_d;
            pend_blk_q <= pend_blk_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
        end
    end

    // Both outputs decode from the same registers, so they switch in the
    // same cycle. digit_out ignores blanking, and only the anode is gated.
    always_comb begin
        anode = 4'b1111;
        if (!act_blk_q[idx_q]) anode[idx_q] = 1'b0;
        digit_out   = act_dig_q[idx_q*4 +: 4];
        update_ack  = ack_q;
        frame_start = fs_q;
    end

endmodule
